hline_setup: RTL and testbench

- Hardware span-setup stage directly upstream of the hline_zbuff FSM.
- Accepts one raw horizontal span (x1, x2, y, z1, z2, colour) and orders endpoints so xl <= xr.
- Computes the depth slope/remainder with a sequential restoring divider and the framebuffer/z-buffer row addresses.
- Pulses start to the hline_zbuff FSM, then holds its operands stable until that FSM reports done.

---
 rtl/hline_setup_if.sv | 39 +++
 rtl/hline_setup.sv | 170 +++++++++++++++++
 tb/tb_hline_setup.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hline_setup_if.sv
// Span request and line-issue signals between the span source, hline_setup
// and the downstream hline_zbuff FSM.
interface hline_setup_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] x1;
    logic [15:0] x2;
    logic [15:0] y;
    logic [31:0] z1;
    logic [31:0] z2;
    logic [31:0] rgbx_in;
    logic [31:0] fb_base;
    logic [31:0] zbuff_base;
    logic [31:0] fb_addr;
    logic [31:0] zbuff_addr;
    logic [31:0] dx;
    logic [31:0] slope;
    logic [31:0] z_start;
    logic [31:0] rem;
    logic [31:0] err;
    logic [31:0] rgbx;
    logic        line_start;
    logic        line_done;
    logic        rejected;
    logic        busy;
    logic [15:0] lines_issued;

    modport slave (
        input  req_valid, x1, x2, y, z1, z2, rgbx_in, fb_base, zbuff_base, line_done,
        output req_ready, fb_addr, zbuff_addr, dx, slope, z_start, rem, err, rgbx,
               line_start, rejected, busy, lines_issued
    );

    modport master (
        output req_valid, x1, x2, y, z1, z2, rgbx_in, fb_base, zbuff_base, line_done,
        input  req_ready, fb_addr, zbuff_addr, dx, slope, z_start, rem, err, rgbx,
               line_start, rejected, busy, lines_issued
    );
endinterface

// File: rtl/hline_setup.sv
// Span setup ahead of hline_zbuff: orders endpoints, divides out the depth slope
// with a 32-cycle restoring divider, forms row addresses and issues the line.
//
// state  | meaning
// IDLE   | ready for a span request
// SETUP  | order endpoints, register addresses, choose reject/issue/divide
// DIVIDE | one quotient bit per cycle, 32 cycles
// ISSUE  | pulse line_start, count the line
// WAIT   | hold operands until hline_zbuff reports done
module hline_setup #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int LOG2_STRIDE = 12
) (
    input  logic         clk,
    input  logic         nreset,
    hline_setup_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DIVIDE, S_ISSUE, S_WAIT} state_t;

    state_t      state;
    logic [15:0] lx1, lx2, ly;
    logic [31:0] lz1, lz2, lrgbx, lfb, lzb;

    logic [31:0] fb_addr_r, zbuff_addr_r, dx_r, slope_r, z_start_r, rem_r, err_r, rgbx_r;
    logic        line_start_r, rejected_r;
    logic [15:0] lines_issued_r;

    logic [31:0] div_q;
    logic [15:0] div_r, div_d;
    logic        div_neg;
    logic [4:0]  cnt;

    logic [15:0] xl, xr, divisor;
    logic [31:0] zl, zr, dz_mag, row_off, col_off;
    logic [32:0] dz;
    logic        reject;

    always_comb begin
        if (lx1 > lx2) begin
            xl = lx2; xr = lx1; zl = lz2; zr = lz1;
        end else begin
            xl = lx1; xr = lx2; zl = lz1; zr = lz2;
        end
        divisor = xr - xl;
        dz      = {1'b0, zr} - {1'b0, zl};
        dz_mag  = dz[32] ? (~dz[31:0] + 32'd1) : dz[31:0];
        row_off = 32'(ly) << LOG2_STRIDE;
        col_off = 32'(xl) << 2;
        reject  = (ly >= 16'(SCREEN_H)) || (xl >= 16'(SCREEN_W));
    end

    // Remainder is always below the 16-bit divisor, so the partial remainder
    // only needs 17 bits after the shift.
    logic [16:0] div_shift;
    logic        div_ge;
    logic [15:0] div_r_nxt;
    logic [31:0] div_q_nxt;

    always_comb begin
        div_shift = {div_r, div_q[31]};
        div_ge    = div_shift >= {1'b0, div_d};
        div_r_nxt = div_ge ? 16'(div_shift - {1'b0, div_d}) : div_shift[15:0];
        div_q_nxt = {div_q[30:0], div_ge};
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state          <= S_IDLE;
            lx1            <= '0;
            lx2            <= '0;
            ly             <= '0;
            lz1            <= '0;
            lz2            <= '0;
            lrgbx          <= '0;
            lfb            <= '0;
            lzb            <= '0;
            fb_addr_r      <= '0;
            zbuff_addr_r   <= '0;
            dx_r           <= '0;
            slope_r        <= '0;
            z_start_r      <= '0;
            rem_r          <= '0;
            err_r          <= '0;
            rgbx_r         <= '0;
            line_start_r   <= 1'b0;
            rejected_r     <= 1'b0;
            lines_issued_r <= '0;
            div_q          <= '0;
            div_r          <= '0;
            div_d          <= '0;
            div_neg        <= 1'b0;
            cnt            <= '0;
        end else begin
            line_start_r <= 1'b0;
            rejected_r   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        lx1   <= bus.x1;
                        lx2   <= bus.x2;
                        ly    <= bus.y;
                        lz1   <= bus.z1;
                        lz2   <= bus.z2;
                        lrgbx <= bus.rgbx_in;
                        lfb   <= bus.fb_base;
                        lzb   <= bus.zbuff_base;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    fb_addr_r    <= lfb + row_off + col_off;
                    zbuff_addr_r <= lzb + row_off + col_off;
                    dx_r         <= 32'(divisor) + 32'd1;
                    z_start_r    <= zl;
                    err_r        <= {17'b0, divisor[15:1]};
                    rgbx_r       <= lrgbx;
                    div_q        <= dz_mag;
                    div_r        <= '0;
                    div_d        <= divisor;
                    div_neg      <= dz[32];
                    cnt          <= 5'd31;
                    if (reject) begin
                        rejected_r <= 1'b1;
                        state      <= S_IDLE;
                    end else if (divisor == 16'd0) begin
                        slope_r <= '0;
                        rem_r   <= '0;
                        state   <= S_ISSUE;
                    end else begin
                        state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    div_q <= div_q_nxt;
                    div_r <= div_r_nxt;
                    cnt   <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        slope_r <= div_neg ? (~div_q_nxt + 32'd1) : div_q_nxt;
                        rem_r   <= 32'(div_r_nxt);
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    line_start_r   <= 1'b1;
                    lines_issued_r <= lines_issued_r + 16'd1;
                    state          <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.line_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = (state == S_IDLE);
    assign bus.busy         = (state != S_IDLE);
    assign bus.fb_addr      = fb_addr_r;
    assign bus.zbuff_addr   = zbuff_addr_r;
    assign bus.dx           = dx_r;
    assign bus.slope        = slope_r;
    assign bus.z_start      = z_start_r;
    assign bus.rem          = rem_r;
    assign bus.err          = err_r;
    assign bus.rgbx         = rgbx_r;
    assign bus.line_start   = line_start_r;
    assign bus.rejected     = rejected_r;
    assign bus.lines_issued = lines_issued_r;
endmodule

// File: tb/tb_hline_setup.sv
// Directed bench for hline_setup: expected span results are queued at request
// time and compared when line_start fires.
module tb_hline_setup;
    logic clk;
    logic nreset;
    hline_setup_if bus();

    hline_setup #(.SCREEN_W(640), .SCREEN_H(480), .LOG2_STRIDE(12)) dut (
        .clk(clk), .nreset(nreset), .bus(bus)
    );

    typedef struct {
        logic [15:0] x1, x2, y;
        logic [31:0] z1, z2, rgbx, fb, zb;
    } span_t;

    typedef struct {
        logic [31:0] dx, slope, rem, err, z_start, fb_addr, zbuff_addr, rgbx;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_lines = 16'd0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input span_t s);
        exp_t        e;
        logic [15:0] xl, xr;
        logic [31:0] zl, zr;
        longint      d, dzl, mag;
        if (s.x1 > s.x2) begin
            xl = s.x2; xr = s.x1; zl = s.z2; zr = s.z1;
        end else begin
            xl = s.x1; xr = s.x2; zl = s.z1; zr = s.z2;
        end
        d   = longint'(xr) - longint'(xl);
        dzl = longint'(zr) - longint'(zl);
        mag = (dzl < 0) ? -dzl : dzl;
        e.dx         = 32'(d + 1);
        e.err        = 32'(d / 2);
        e.z_start    = zl;
        e.slope      = (d == 0) ? 32'd0 : 32'(dzl / d);
        e.rem        = (d == 0) ? 32'd0 : 32'(mag % d);
        e.fb_addr    = s.fb + 32'(s.y) * 32'd4096 + 32'(xl) * 32'd4;
        e.zbuff_addr = s.zb + 32'(s.y) * 32'd4096 + 32'(xl) * 32'd4;
        e.rgbx       = s.rgbx;
        e.lat        = (d == 0) ? 3 : 35;
        return e;
    endfunction

    // Leaves the bench in cycle 1 after the transfer edge (SETUP).
    task automatic drive(input span_t s, input bit push);
        int n = 0;
        while (!bus.req_ready && n < 100) begin
            step();
            n++;
        end
        bus.x1 = s.x1; bus.x2 = s.x2; bus.y = s.y;
        bus.z1 = s.z1; bus.z2 = s.z2; bus.rgbx_in = s.rgbx;
        bus.fb_base = s.fb; bus.zbuff_base = s.zb;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        bus.x1 = 16'hFFFF; bus.y = 16'hFFFF; bus.fb_base = 32'hDEADBEEF;
        if (push) sb.push_back(model(s));
    endtask

    task automatic await_line(input string tag, input int hold);
        exp_t e;
        int   n = 1;
        bit   seen = 1'b0;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        while (n < 60) begin
            if (bus.line_start) begin
                seen = 1'b1;
                break;
            end
            check({tag, "_busy"}, 32'(bus.busy), 32'd1);
            step();
            n++;
        end
        exp_lines = exp_lines + 16'd1;
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, n, e.lat);
        check({tag, "_dx"}, bus.dx, e.dx);
        check({tag, "_slope"}, bus.slope, e.slope);
        check({tag, "_rem"}, bus.rem, e.rem);
        check({tag, "_err"}, bus.err, e.err);
        check({tag, "_z_start"}, bus.z_start, e.z_start);
        check({tag, "_fb_addr"}, bus.fb_addr, e.fb_addr);
        check({tag, "_zbuff_addr"}, bus.zbuff_addr, e.zbuff_addr);
        check({tag, "_rgbx"}, bus.rgbx, e.rgbx);
        check({tag, "_lines"}, 32'(bus.lines_issued), 32'(exp_lines));
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
            check({tag, "_hold_start"}, 32'(bus.line_start), 32'd0);
            check({tag, "_hold_fb"}, bus.fb_addr, e.fb_addr);
            check({tag, "_hold_slope"}, bus.slope, e.slope);
        end
        bus.line_done = 1'b1;
        step();
        bus.line_done = 1'b0;
        check({tag, "_ready_after_done"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_stable_after_done"}, bus.dx, e.dx);
    endtask

    task automatic reject_span(input string tag, input span_t s);
        int starts = 0;
        drive(s, 1'b0);
        check({tag, "_ready_c1"}, 32'(bus.req_ready), 32'd0);
        step();
        check({tag, "_rejected"}, 32'(bus.rejected), 32'd1);
        check({tag, "_ready_c2"}, 32'(bus.req_ready), 32'd1);
        step();
        check({tag, "_rejected_pulse"}, 32'(bus.rejected), 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (bus.line_start) starts++;
            step();
        end
        check({tag, "_no_start"}, starts, 0);
        check({tag, "_lines"}, 32'(bus.lines_issued), 32'(exp_lines));
    endtask

    span_t s;

    initial begin
        nreset = 1'b0;
        bus.req_valid = 1'b0; bus.line_done = 1'b0;
        bus.x1 = '0; bus.x2 = '0; bus.y = '0; bus.z1 = '0; bus.z2 = '0;
        bus.rgbx_in = '0; bus.fb_base = '0; bus.zbuff_base = '0;
        #12 nreset = 1'b1;
        step();
        check("rst_ready", 32'(bus.req_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_start", 32'(bus.line_start), 32'd0);
        check("rst_lines", 32'(bus.lines_issued), 32'd0);
        check("rst_fb", bus.fb_addr, 32'd0);
        check("rst_slope", bus.slope, 32'd0);

        s = '{x1:16'd10, x2:16'd20, y:16'd2, z1:32'd100, z2:32'd135,
              rgbx:32'h11223344, fb:32'h10000000, zb:32'h20000000};
        drive(s, 1'b1);
        await_line("basic", 0);
        check("basic_fb_const", bus.fb_addr, 32'h10002028);
        check("basic_slope_const", bus.slope, 32'd3);

        s = '{x1:16'd20, x2:16'd10, y:16'd2, z1:32'd135, z2:32'd100,
              rgbx:32'h11223344, fb:32'h10000000, zb:32'h20000000};
        drive(s, 1'b1);
        await_line("swap", 0);

        s = '{x1:16'd0, x2:16'd4, y:16'd7, z1:32'd100, z2:32'd90,
              rgbx:32'hCAFE0001, fb:32'h00400000, zb:32'h00800000};
        drive(s, 1'b1);
        await_line("neg", 0);
        check("neg_slope_const", bus.slope, 32'hFFFFFFFE);

        bus.line_done = 1'b1;
        s = '{x1:16'd7, x2:16'd7, y:16'd479, z1:32'd5, z2:32'd5,
              rgbx:32'h0000FFFF, fb:32'hFFFFFF00, zb:32'h00001000};
        drive(s, 1'b1);
        await_line("zero_div", 0);

        s = '{x1:16'd639, x2:16'd0, y:16'd1, z1:32'd0, z2:32'hFFFFFFFF,
              rgbx:32'h5A5A5A5A, fb:32'hFFFFF000, zb:32'h12345678};
        drive(s, 1'b1);
        await_line("wide", 0);

        for (int k = 0; k < 3; k++) begin
            s.x1 = 16'($urandom_range(639, 0)); s.x2 = 16'($urandom_range(639, 0));
            s.y = 16'($urandom_range(479, 0));
            s.z1 = $urandom; s.z2 = $urandom; s.rgbx = $urandom;
            s.fb = $urandom; s.zb = $urandom;
            drive(s, 1'b1);
            await_line("rand", 0);
        end

        s = '{x1:16'd10, x2:16'd20, y:16'd480, z1:32'd1, z2:32'd2,
              rgbx:32'd0, fb:32'd0, zb:32'd0};
        reject_span("rej_y", s);
        s.y = 16'd3; s.x1 = 16'd700; s.x2 = 16'd700;
        reject_span("rej_x", s);

        s = '{x1:16'd10, x2:16'd300, y:16'd9, z1:32'd1000, z2:32'd5,
              rgbx:32'h77777777, fb:32'h40000000, zb:32'h50000000};
        drive(s, 1'b0);
        for (int i = 0; i < 11; i++) step();
        nreset = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_fb", bus.fb_addr, 32'd0);
        check("abort_dx", bus.dx, 32'd0);
        check("abort_lines", 32'(bus.lines_issued), 32'd0);
        exp_lines = 16'd0;
        #2 nreset = 1'b1;
        begin
            int starts = 0;
            for (int i = 0; i < 40; i++) begin
                step();
                if (bus.line_start) starts++;
            end
            check("abort_no_start", starts, 0);
        end
        check("abort_ready", 32'(bus.req_ready), 32'd1);

        s = '{x1:16'd10, x2:16'd20, y:16'd2, z1:32'd100, z2:32'd135,
              rgbx:32'h11223344, fb:32'h10000000, zb:32'h20000000};
        drive(s, 1'b1);
        await_line("after_abort", 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
